rv32i_lsu: RTL

Load/store unit directly downstream of the RV32I decode/execute stage. It executes lb/lh/lw/lbu/lhu/sb/sh/sw requests: it checks alignment and range, talks to a 32-bit word-only data memory (no byte strobes) over a req/ack handshake, and returns sign- or zero-extended load data. Sub-word stores use a read-modify-write sequence. Failed accesses raise a fault to the core.

---
 rtl/rv32i_lsu_pkg.sv | 23 ++
 rtl/rv32i_lsu_if.sv | 33 +++
 rtl/rv32i_lsu_align.sv | 36 +++
 rtl/rv32i_lsu.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rv32i_lsu_pkg.sv
// Shared types and funct3 encodings for the RV32I load/store unit.
package rv32i_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic w_common;
    w_common = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return we ? w_common : (w_common || (f3 == F3_BU) || (f3 == F3_HU));
  endfunction

endpackage

// File: rtl/rv32i_lsu_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
interface rv32i_lsu_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  // slave: the LSU itself; master: the core plus data memory around it
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rv32i_lsu_align.sv
// Lane handling: little-endian load extract/extend and sub-word store merge.
module rv32i_lsu_align
  import rv32i_lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_off, 3'b000} +: 8];
    w_half = i_word[{i_off[1], 4'b0000} +: 16];

    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'h000000, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'h0000, w_half};
      default: o_load = i_word;
    endcase

    o_merged = i_word;
    case (i_funct3)
      F3_B:    o_merged[{i_off, 3'b000} +: 8]     = i_wdata[7:0];
      F3_H:    o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: checks, word-only memory handshake with timeout,
// read-modify-write for sub-word stores.
module rv32i_lsu
  import rv32i_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 15
) (
  input logic        clk,
  input logic        rst,
  rv32i_lsu_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_req_ready;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_fault;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic              w_accept;
  logic              w_half;
  logic              w_word;
  logic              w_fault;
  logic              w_expire;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

  rv32i_lsu_align u_align (
    .i_word   (bus.mem_rdata),
    .i_wdata  (r_wdata),
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_comb begin
    w_accept = bus.req_valid && r_req_ready;
    w_half   = (bus.req_funct3 == F3_H) || (bus.req_funct3 == F3_HU);
    w_word   = (bus.req_funct3 == F3_W);
    w_fault  = !f3_legal(bus.req_we, bus.req_funct3)
            || (w_half && bus.req_addr[0])
            || (w_word && (bus.req_addr[1:0] != 2'b00))
            || ((bus.req_addr >> ADDR_W) != '0);
    // this no-ack cycle would bring the wait count up to TIMEOUT
    w_expire = !bus.mem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_f3         <= '0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we        <= bus.req_we;
            r_f3        <= bus.req_funct3;
            r_off       <= bus.req_addr[1:0];
            r_wdata     <= bus.req_wdata;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            if (w_fault) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              if (bus.req_we && w_word) begin
                r_state     <= WR;
                r_mem_we    <= 1'b1;
                r_mem_wdata <= bus.req_wdata;
              end else begin
                r_state  <= RD;
                r_mem_we <= 1'b0;
              end
            end
          end
        end
        RD: begin
          if (bus.mem_ack) begin
            if (r_we) begin
              r_state     <= WR;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= w_merged;
              r_cnt       <= '0;
            end else begin
              r_state      <= RESP;
              r_mem_req    <= 1'b0;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b0;
              r_resp_rdata <= w_load;
            end
          end else if (w_expire) begin
            r_state      <= RESP;
            r_mem_req    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WR: begin
          if (bus.mem_ack || w_expire) begin
            r_state      <= RESP;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_fault <= !bus.mem_ack;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_fault <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_fault = r_resp_fault;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule
